// File: rtl/decryption_pkg.sv
// Shared constants and types for the decryption front end: engine selects,
// the end-of-message token and the dispatcher state encoding.
package decryption_pkg;

    localparam logic [1:0] SEL_CAESAR  = 2'd0;
    localparam logic [1:0] SEL_SCYTALE = 2'd1;
    localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
    localparam logic [1:0] SEL_INVALID = 2'd3;

    localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_RUN        = 2'd3
    } state_e;

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        return 3'b001 << sel;
    endfunction

endpackage

// File: rtl/engine_output_mux.sv
// Registered return path: picks the selected engine's character/valid and
// presents it one cycle later; valid is suppressed unless enabled.
module engine_output_mux #(
    parameter int D_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [1:0]           i_sel,
    input  logic [3*D_WIDTH-1:0] eng_data_i,
    input  logic [2:0]           eng_valid_i,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    logic                 w_take;
    logic [D_WIDTH-1:0]   r_data;
    logic                 r_valid;

    assign w_take = i_en & eng_valid_i[i_sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_take;
            // Data holds its last value between engine characters.
            if (w_take)
                r_data <= eng_data_i[i_sel*D_WIDTH +: D_WIDTH];
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule

// File: rtl/decryption_dispatcher.sv
// Routes one message at a time to the selected decryption engine and muxes its
// result back. Optional engine-start watchdog: define DISPATCH_TIMEOUT_EN.
module decryption_dispatcher #(
    parameter int               D_WIDTH                = 8,
    parameter int               MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
    parameter int               TIMEOUT_CYCLES         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [1:0]           sel_i,
    output logic                 busy_o,
    output logic [D_WIDTH-1:0]   eng_data_o,
    output logic [2:0]           eng_valid_o,
    input  logic [2:0]           eng_busy_i,
    input  logic [3*D_WIDTH-1:0] eng_data_i,
    input  logic [2:0]           eng_valid_i,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 err_o
);
    import decryption_pkg::*;

    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);

    state_e               r_state;
    logic [1:0]           r_sel;
    logic [CNT_W-1:0]     r_count;
    logic                 r_busy;
    logic [D_WIDTH-1:0]   r_eng_data;
    logic [2:0]           r_eng_valid;
    logic                 r_err;

    logic                 w_is_token;
    logic                 w_eng_busy;
    logic                 w_run;

    assign w_is_token = (data_i == START_DECRYPTION_TOKEN);
    assign w_eng_busy = eng_busy_i[r_sel];
    assign w_run      = (r_state == ST_RUN);

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= SEL_CAESAR;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_eng_data  <= '0;
            r_eng_valid <= '0;
            r_err       <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_eng_valid <= '0;
            r_err       <= 1'b0;
            case (r_state)
                // A lone token in IDLE is an empty message and is ignored.
                ST_IDLE: begin
                    if (valid_i && !w_is_token) begin
                        if (sel_i == SEL_INVALID) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sel       <= sel_i;
                            r_eng_data  <= data_i;
                            r_eng_valid <= sel_onehot(sel_i);
                            r_count     <= CNT_W'(1);
                            r_state     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (valid_i) begin
                        if (w_is_token) begin
                            r_eng_data  <= data_i;
                            r_eng_valid <= sel_onehot(r_sel);
                            r_busy      <= 1'b1;
                            r_state     <= ST_WAIT_START;
`ifdef DISPATCH_TIMEOUT_EN
                            r_to_cnt    <= '0;
`endif
                        end else if (r_count == CNT_W'(MAX_NOF_CHARS)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_eng_data  <= data_i;
                            r_eng_valid <= sel_onehot(r_sel);
                            r_count     <= r_count + 1'b1;
                        end
                    end
                end
                ST_WAIT_START: begin
                    if (w_eng_busy) begin
                        r_state <= ST_RUN;
`ifdef DISPATCH_TIMEOUT_EN
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                ST_RUN: begin
                    if (!w_eng_busy) begin
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    engine_output_mux #(
        .D_WIDTH (D_WIDTH)
    ) u_out_mux (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_run),
        .i_sel       (r_sel),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o)
    );

    assign busy_o      = r_busy;
    assign eng_data_o  = r_eng_data;
    assign eng_valid_o = r_eng_valid;
    assign err_o       = r_err;

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Directed self-checking bench for decryption_dispatcher; the watchdog
// scenario is exercised when DISPATCH_TIMEOUT_EN is defined.
module tb_decryption_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [1:0]  sel_i;
    logic        busy_o;
    logic [7:0]  eng_data_o;
    logic [2:0]  eng_valid_o;
    logic [2:0]  eng_busy_i;
    logic [23:0] eng_data_i;
    logic [2:0]  eng_valid_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] msg [5];

    always #5 clk = ~clk;

    decryption_dispatcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .sel_i       (sel_i),
        .busy_o      (busy_o),
        .eng_data_o  (eng_data_o),
        .eng_valid_o (eng_valid_o),
        .eng_busy_i  (eng_busy_i),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the edge that registered them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h44; msg[4] = 8'h45;
        rst_n = 1'b0; data_i = '0; valid_i = 1'b0; sel_i = 2'd0;
        eng_busy_i = '0; eng_data_i = '0; eng_valid_i = '0;
        tick(); tick();
        check("rst_busy",    32'(busy_o),      32'd0);
        check("rst_engvld",  32'(eng_valid_o), 32'd0);
        check("rst_engdata", 32'(eng_data_o),  32'd0);
        check("rst_data",    32'(data_o),      32'd0);
        check("rst_valid",   32'(valid_o),     32'd0);
        check("rst_err",     32'(err_o),       32'd0);
        rst_n = 1'b1;
        tick();

        // Zigzag message "ABCDE" + token
        sel_i = 2'd2; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = msg[i];
            tick();
            check("zz_vld",  32'(eng_valid_o), 32'b100);
            check("zz_data", 32'(eng_data_o),  32'(msg[i]));
            check("zz_busy", 32'(busy_o),      32'd0);
        end
        data_i = 8'hFA;
        tick();
        check("zz_tok_vld",  32'(eng_valid_o), 32'b100);
        check("zz_tok_data", 32'(eng_data_o),  32'hFA);
        check("zz_tok_busy", 32'(busy_o),      32'd1);
        valid_i = 1'b0;
        tick();
        check("zz_pulse",    32'(eng_valid_o), 32'd0);
        check("zz_busy_w",   32'(busy_o),      32'd1);
        tick();
        eng_busy_i = 3'b100;
        tick();
        check("zz_busy_run", 32'(busy_o),      32'd1);
        eng_data_i = {8'h5A, 8'h00, 8'h11};
        eng_valid_i = 3'b101;
        valid_i = 1'b1; data_i = 8'h58;
        tick();
        check("run_valid",   32'(valid_o),     32'd1);
        check("run_data",    32'(data_o),      32'h5A);
        check("run_drop",    32'(eng_valid_o), 32'd0);
        check("run_noerr",   32'(err_o),       32'd0);
        valid_i = 1'b0;
        eng_data_i = {8'h5A, 8'h00, 8'h22};
        eng_valid_i = 3'b001;
        tick();
        check("run_other",   32'(valid_o),     32'd0);
        eng_valid_i = 3'b000;
        eng_busy_i = 3'b000;
        tick();
        check("zz_busy_fall", 32'(busy_o),     32'd0);

        // Invalid select
        sel_i = 2'd3; valid_i = 1'b1; data_i = 8'h41;
        tick();
        check("inv_vld",  32'(eng_valid_o), 32'd0);
        check("inv_err",  32'(err_o),       32'd1);
        valid_i = 1'b0;
        tick();
        check("inv_pulse", 32'(err_o),      32'd0);
        sel_i = 2'd0; valid_i = 1'b1; data_i = 8'hFA;
        tick();
        check("idle_tok_vld", 32'(eng_valid_o), 32'd0);
        check("idle_tok_err", 32'(err_o),       32'd0);
        check("idle_tok_busy", 32'(busy_o),     32'd0);

        // Caesar overflow: 51 characters, sel_i changes after the first
        for (int i = 0; i < 51; i++) begin
            sel_i = (i == 0) ? 2'd0 : 2'd1;
            data_i = 8'(8'h30 + i);
            tick();
            if (i < 50) begin
                check("ovf_vld", 32'(eng_valid_o), 32'b001);
                check("ovf_err", 32'(err_o),       32'd0);
            end else begin
                check("ovf_drop", 32'(eng_valid_o), 32'd0);
                check("ovf_err51", 32'(err_o),      32'd1);
            end
        end
        data_i = 8'hFA;
        tick();
        check("ovf_tok_vld",  32'(eng_valid_o), 32'b001);
        check("ovf_tok_data", 32'(eng_data_o),  32'hFA);
        check("ovf_tok_err",  32'(err_o),       32'd0);
        valid_i = 1'b0;
`ifndef DISPATCH_TIMEOUT_EN
        for (int k = 0; k < 6; k++) begin
            tick();
            check("wait_busy", 32'(busy_o), 32'd1);
            check("wait_err",  32'(err_o),  32'd0);
        end
`endif
        eng_busy_i = 3'b001;
        tick();
        eng_busy_i = 3'b000;
        tick();
        check("ovf_busy_fall", 32'(busy_o), 32'd0);

        // Reset in the middle of loading
        sel_i = 2'd0; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'(8'h61 + i);
            tick();
        end
        rst_n = 1'b0; data_i = 8'h64;
        tick();
        check("mid_rst_vld",  32'(eng_valid_o), 32'd0);
        check("mid_rst_data", 32'(eng_data_o),  32'd0);
        check("mid_rst_busy", 32'(busy_o),      32'd0);
        check("mid_rst_err",  32'(err_o),       32'd0);
        rst_n = 1'b1; valid_i = 1'b0;
        tick();
        sel_i = 2'd1; valid_i = 1'b1; data_i = 8'h51;
        tick();
        check("post_rst_vld",  32'(eng_valid_o), 32'b010);
        check("post_rst_data", 32'(eng_data_o),  32'h51);
        data_i = 8'hFA;
        tick();
        check("post_rst_tok", 32'(eng_valid_o), 32'b010);
        valid_i = 1'b0;

`ifdef DISPATCH_TIMEOUT_EN
        // Engine never starts: watchdog fires 4 cycles after WAIT_START entry
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                check("to_early_err",  32'(err_o),  32'd0);
                check("to_early_busy", 32'(busy_o), 32'd1);
            end else begin
                check("to_err",  32'(err_o),  32'd1);
                check("to_busy", 32'(busy_o), 32'd0);
            end
        end
        tick();
        check("to_pulse", 32'(err_o), 32'd0);
`else
        eng_busy_i = 3'b010;
        tick();
        eng_busy_i = 3'b000;
        tick();
        check("post_rst_fall", 32'(busy_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decryption_dispatcher.md
# decryption_dispatcher

Front-end controller that shares one encrypted-character stream among three decryption engines (0 = caesar, 1 = scytale, 2 = zigzag). It latches the engine select at the first character of a message, forwards characters and the start token to that engine only, holds upstream off while the engine works, and muxes the engine's decrypted output back onto a single output port. It sits between the input source and the engine bank in the decryption top level.

## Interface
- D_WIDTH, 8, character width
- MAX_NOF_CHARS, 50, maximum characters per message
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption marker
- TIMEOUT_CYCLES, 4, engine start watchdog limit (used only with macro)

- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- data_i  in  D_WIDTH  encrypted character or token
- valid_i  in  1  data_i qualifier
- sel_i  in  2  engine select; 3 is invalid
- busy_o  out  1  upstream must not send while high
- eng_data_o  out  D_WIDTH  shared data bus to all engines
- eng_valid_o  out  3  one-hot valid to selected engine
- eng_busy_i  in  3  per-engine busy
- eng_data_i  in  3*D_WIDTH  engine outputs, engine e at [e*D_WIDTH +: D_WIDTH]
- eng_valid_i  in  3  per-engine output valid
- data_o  out  D_WIDTH  decrypted character
- valid_o  out  1  data_o qualifier
- err_o  out  1  one-cycle error pulse

## Operation
- Reset values: busy_o=0, eng_data_o=0, eng_valid_o=0, data_o=0, valid_o=0, err_o=0; state IDLE, count=0, sel=0.
- States: IDLE, LOAD, WAIT_START, RUN.
- IDLE: valid_i with a non-token character and sel_i<3 -> latch sel, forward character, count=1, go LOAD. sel_i==3 -> character dropped, err_o pulse, stay IDLE. Token with count 0 -> ignored, no forward, no error.
- LOAD: non-token character -> forward to latched engine, count+1; if count already MAX_NOF_CHARS -> drop, err_o pulse, count unchanged. Token -> forward, busy_o=1, go WAIT_START. sel_i ignored.
- WAIT_START: wait for eng_busy_i[sel]=1, then go RUN.
- RUN: data_o/valid_o follow eng_data_i/eng_valid_i of sel; other engines' outputs ignored. On eng_busy_i[sel]=0 -> busy_o=0, count=0, go IDLE.
- valid_i while busy_o=1: dropped silently.
- count width: $clog2(MAX_NOF_CHARS+1).
- rst_n low in any state: all registers to reset values next edge; engines receive no further valid.

## Timing
- Forward latency 1 cycle: eng_data_o/eng_valid_o[sel] registered from data_i/valid_i; eng_valid_o high exactly one cycle per accepted character/token.
- busy_o rises the cycle after the token is sampled.
- Output latency 1 cycle: data_o/valid_o registered from selected engine inputs.
- busy_o falls the cycle after eng_busy_i[sel] is sampled low; a new message may start in that next cycle.
- err_o registered, one cycle after offending input.

## Configuration
- DISPATCH_TIMEOUT_EN defined: WAIT_START counts cycles; if eng_busy_i[sel] not high within TIMEOUT_CYCLES -> err_o pulse, busy_o=0, count=0, go IDLE.
- Undefined: WAIT_START waits indefinitely; no counter synthesized.

## Structure
- Shared package decryption_pkg: engine select constants (SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2), START_DECRYPTION_TOKEN, state enum type.
- One sub-module: engine_output_mux (registered select of eng_data_i/eng_valid_i by sel, enable in RUN).

## Test plan
- sel_i=2, send "ABCDE" then 8'hFA, zigzag model busy 2 cycles later -> eng_valid_o=3'b100 six cycles, busy_o high from token+1 until busy fall+1, data_o mirrors engine output 1 cycle late.
- sel_i=3, send 'A' -> no eng_valid_o, err_o single pulse, state IDLE.
- sel_i=0, 51 characters then token -> 50 forwarded, err_o one pulse on 51st, token forwarded.
- valid_i 'X' during RUN -> not forwarded, no err_o.
- With DISPATCH_TIMEOUT_EN, engine never raises busy -> err_o pulse 4 cycles after WAIT_START entry, busy_o=0.
- rst_n low mid-LOAD after 3 characters -> all outputs 0 next cycle; subsequent message with sel_i=1 routes to eng_valid_o=3'b010.
